btb_line_table: RTL and testbench
=================================

Name: btb_line_table

Overview:
- Fully-associative branch target buffer storage and fill control.
- Sits directly upstream of the LRU counter block and drives its `en`/`hit`/`hit_line` inputs.
- Consumes that block's `lru_line` to choose the victim on allocation.
- Serves fetch-stage lookups and execute-stage branch-resolution updates.

Parameters:
- DATA_WIDTH, 32, width of PC and target addresses.
- LINE_NUM, `BTB_LINE_NUM (8), number of BTB lines.
- LINE_SIZE, `BTB_LINE_SIZE (3), line index width; equals clog2(LINE_NUM).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- lookup_valid  in  1  fetch lookup request this cycle.
- lookup_pc  in  DATA_WIDTH  PC to look up.
- pred_valid  out  1  registered lookup result is valid.
- pred_hit  out  1  lookup PC found in a valid line.
- pred_target  out  DATA_WIDTH  stored target on hit, else 0.
- update_valid  in  1  branch resolved this cycle.
- update_pc  in  DATA_WIDTH  resolved branch PC.
- update_target  in  DATA_WIDTH  resolved target.
- update_taken  in  1  branch was taken.
- lru_line  in  LINE_SIZE  least-recently-used line from the LRU block.
- lru_en  out  1  one-cycle touch pulse to the LRU block.
- lru_hit  out  1  touch names an explicit line (1) or the LRU victim (0).
- lru_hit_line  out  LINE_SIZE  line being touched.

Behaviour:
- Storage: per line, valid bit, tag (full PC), target.
- Reset (rst=0, async): all valid bits 0. pred_valid, pred_hit, pred_target, lru_en, lru_hit, lru_hit_line all 0. Tag/target contents don't-care.
- Lookup, latency 1:
  - In cycle N, lookup_valid=1 compares lookup_pc against all valid tags.
  - In cycle N+1: pred_valid=1; pred_hit=match; pred_target=matching target or 0.
  - lookup_valid=0 gives pred_valid=0, pred_hit=0, pred_target=0 next cycle.
- Read-before-write: a lookup in the same cycle as an update sees pre-update contents (unless BTB_BYPASS_EN).
- Update (cycle N, update_valid=1):
  - Tag match, taken: rewrite target.
  - Tag match, not taken: clear valid of that line.
  - Tag miss, taken: allocate, then write tag/target and set valid.
    - Victim is the lowest-index invalid line if any exists.
    - Otherwise victim is lru_line, sampled in cycle N.
  - Tag miss, not taken: no change.
  - Writes take effect at the cycle-N edge.
- LRU touch, registered, pulsed in cycle N+1 for one cycle:
  - Update match, taken: lru_en=1, lru_hit=1, lru_hit_line=matched line.
  - Allocation into an invalid line: lru_en=1, lru_hit=1, lru_hit_line=that line.
  - Allocation into lru_line: lru_en=1, lru_hit=0, lru_hit_line=0.
  - Update match, not taken: no touch.
  - Lookup hit with no touching update in the same cycle: lru_en=1, lru_hit=1, lru_hit_line=hit line.
  - Simultaneous update touch and lookup hit: the update touch wins and the lookup touch is dropped.
  - Otherwise lru_en=0.
- Tags are unique by construction: allocation only on miss. Back-to-back updates to the same PC see the first write.
- Reset mid-operation: valids clear immediately; any pending registered touch or prediction is discarded.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: a lookup whose lookup_pc equals update_pc in the same cycle returns the post-update view:
  - taken update: pred_hit=1, pred_target=update_target;
  - not-taken update: pred_hit=0.
  - The LRU touch follows the update rule only.
- Undefined: strict read-before-write as above.

Test Plan:
- Reset, then lookup 0x1000 -> next cycle pred_valid=1, pred_hit=0, pred_target=0; lru_en=0.
- Update pc=0x1000, tgt=0x2000, taken, table empty -> line 0 filled; next cycle lru_en=1, lru_hit=1, lru_hit_line=0. Lookup 0x1000 -> pred_hit=1, pred_target=0x2000.
- Fill 8 distinct PCs 0x100..0x800 step 0x100 -> lines 0..7. Ninth update 0x900 taken with lru_line=3 -> line 3 replaced, lru_en=1, lru_hit=0; lookup 0x400 misses, 0x900 hits.
- Update 0x1000 not taken after fill -> valid cleared, no lru_en; later lookup 0x1000 -> pred_hit=0; next taken allocation reuses line 0.
- Same cycle: lookup 0x1000 (hit, line 0) and update 0x3000 taken (new, line 1) -> touch names line 1 only. Same-PC retarget 0x1000 -> 0x5000 with lookup 0x1000: without BTB_BYPASS_EN returns 0x2000, with it returns 0x5000.
- Assert rst low mid-lookup -> pred_valid and lru_en drop to 0 immediately; all subsequent lookups miss.

Source files
------------

// File: rtl/btb_line_table.sv
// Fully-associative branch target buffer: lookups finish in one cycle, updates allocate on a taken miss,
// and registered touch pulses go to the LRU block. Define BTB_BYPASS_EN to forward a same-cycle update to a lookup.
`ifndef BTB_LINE_NUM
  `define BTB_LINE_NUM 8
`endif
`ifndef BTB_LINE_SIZE
  `define BTB_LINE_SIZE 3
`endif

module btb_line_table #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_NUM   = `BTB_LINE_NUM,
  parameter int LINE_SIZE  = `BTB_LINE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  update_valid,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  input  logic [LINE_SIZE-1:0]  lru_line,
  output logic                  lru_en,
  output logic                  lru_hit,
  output logic [LINE_SIZE-1:0]  lru_hit_line
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [LINE_SIZE-1:0]  line_t;

  logic [LINE_NUM-1:0] valid_q, valid_d;
  word_t               tag_q    [LINE_NUM];
  word_t               tag_d    [LINE_NUM];
  word_t               target_q [LINE_NUM];
  word_t               target_d [LINE_NUM];

  logic  pred_valid_q, pred_valid_d;
  logic  pred_hit_q, pred_hit_d;
  word_t pred_target_q, pred_target_d;
  logic  lru_en_q, lru_en_d;
  logic  lru_hit_q, lru_hit_d;
  line_t lru_hit_line_q, lru_hit_line_d;

  // Match and free-line search. Loops run high to low so the lowest index wins.
  logic  lk_hit, up_hit, free_any;
  line_t lk_line, up_line, free_line;
  word_t lk_target;

  always_comb begin
    lk_hit    = 1'b0;
    lk_line   = '0;
    lk_target = '0;
    up_hit    = 1'b0;
    up_line   = '0;
    free_any  = 1'b0;
    free_line = '0;
    for (int i = LINE_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_pc)) begin
        lk_hit    = 1'b1;
        lk_line   = line_t'(i);
        lk_target = target_q[i];
      end
      if (valid_q[i] && (tag_q[i] == update_pc)) begin
        up_hit  = 1'b1;
        up_line = line_t'(i);
      end
      if (!valid_q[i]) begin
        free_any  = 1'b1;
        free_line = line_t'(i);
      end
    end
  end

`ifdef BTB_BYPASS_EN
  logic same_pc;
  assign same_pc = lookup_valid && update_valid && (lookup_pc == update_pc);
`endif

  // NOTE: every signal written here gets a default first, so no path leaves a value held (no latch).
  always_comb begin
    valid_d        = valid_q;
    tag_d          = tag_q;
    target_d       = target_q;
    lru_en_d       = 1'b0;
    lru_hit_d      = 1'b0;
    lru_hit_line_d = '0;

    if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          target_d[up_line] = update_target;
          lru_en_d          = 1'b1;
          lru_hit_d         = 1'b1;
          lru_hit_line_d    = up_line;
        end else begin
          valid_d[up_line] = 1'b0;
        end
      end else if (update_taken) begin
        // Allocation prefers an empty line; only a full table evicts the LRU victim.
        if (free_any) begin
          valid_d[free_line]  = 1'b1;
          tag_d[free_line]    = update_pc;
          target_d[free_line] = update_target;
          lru_en_d            = 1'b1;
          lru_hit_d           = 1'b1;
          lru_hit_line_d      = free_line;
        end else begin
          valid_d[lru_line]  = 1'b1;
          tag_d[lru_line]    = update_pc;
          target_d[lru_line] = update_target;
          lru_en_d           = 1'b1;
        end
      end
    end

    // A lookup touch is dropped whenever the update already produced one.
    if (!lru_en_d && lookup_valid && lk_hit
`ifdef BTB_BYPASS_EN
        && !same_pc
`endif
        ) begin
      lru_en_d       = 1'b1;
      lru_hit_d      = 1'b1;
      lru_hit_line_d = lk_line;
    end

    pred_valid_d  = lookup_valid;
    pred_hit_d    = lookup_valid && lk_hit;
    pred_target_d = pred_hit_d ? lk_target : '0;
`ifdef BTB_BYPASS_EN
    if (same_pc) begin
      pred_hit_d    = update_taken;
      pred_target_d = update_taken ? update_target : '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      pred_valid_q   <= 1'b0;
      pred_hit_q     <= 1'b0;
      pred_target_q  <= '0;
      lru_en_q       <= 1'b0;
      lru_hit_q      <= 1'b0;
      lru_hit_line_q <= '0;
    end else begin
      valid_q        <= valid_d;
      pred_valid_q   <= pred_valid_d;
      pred_hit_q     <= pred_hit_d;
      pred_target_q  <= pred_target_d;
      lru_en_q       <= lru_en_d;
      lru_hit_q      <= lru_hit_d;
      lru_hit_line_q <= lru_hit_line_d;
    end
  end

  // NOTE: tag/target storage is deliberately not reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign pred_valid   = pred_valid_q;
  assign pred_hit     = pred_hit_q;
  assign pred_target  = pred_target_q;
  assign lru_en       = lru_en_q;
  assign lru_hit      = lru_hit_q;
  assign lru_hit_line = lru_hit_line_q;

endmodule

// File: tb/tb_btb_line_table.sv
// Self-checking bench for btb_line_table: directed scenarios plus randomized traffic
// checked every cycle against a behavioural table model.
module tb_btb_line_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid, pred_hit;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc, update_target;
  logic        update_taken;
  logic [2:0]  lru_line;
  logic        lru_en, lru_hit;
  logic [2:0]  lru_hit_line;

  int n_tests = 0;
  int n_fail  = 0;

  btb_line_table dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_hit     (pred_hit),
    .pred_target  (pred_target),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_target(update_target),
    .update_taken (update_taken),
    .lru_line     (lru_line),
    .lru_en       (lru_en),
    .lru_hit      (lru_hit),
    .lru_hit_line (lru_hit_line)
  );

  always #5 clk = ~clk;

  // Reference table: a set of (pc -> target) entries pinned to line slots.
  bit          m_valid [8];
  logic [31:0] m_tag   [8];
  logic [31:0] m_tgt   [8];

  logic        e_pv, e_ph, e_en, e_hit;
  logic [31:0] e_pt;
  logic [2:0]  e_line;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int find(input logic [31:0] pc);
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < 8; i++)
      if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
  endtask

  // Compute what the outputs must show after the coming edge, then apply the update to the table.
  task automatic model_step(input logic lv, input logic [31:0] lpc, input logic uv,
                            input logic [31:0] upc, input logic [31:0] utgt,
                            input logic utk, input logic [2:0] lru);
    int  li, ui, v;
    bit  same;
    li   = find(lpc);
    ui   = find(upc);
    same = 0;
    e_pv = lv;
    e_ph = lv && (li >= 0);
    e_pt = e_ph ? m_tgt[li] : 32'h0;
`ifdef BTB_BYPASS_EN
    same = lv && uv && (lpc == upc);
    if (same) begin
      e_ph = utk;
      e_pt = utk ? utgt : 32'h0;
    end
`endif
    e_en = 0; e_hit = 0; e_line = 0;
    if (uv) begin
      if (ui >= 0) begin
        if (utk) begin
          m_tgt[ui] = utgt;
          e_en = 1; e_hit = 1; e_line = 3'(ui);
        end else begin
          m_valid[ui] = 0;
        end
      end else if (utk) begin
        v = first_free();
        if (v >= 0) begin
          e_en = 1; e_hit = 1; e_line = 3'(v);
        end else begin
          v = int'(lru);
          e_en = 1;
        end
        m_valid[v] = 1; m_tag[v] = upc; m_tgt[v] = utgt;
      end
    end
    if (!e_en && lv && li >= 0 && !same) begin
      e_en = 1; e_hit = 1; e_line = 3'(li);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic [31:0] utgt,
                       input logic utk, input logic [2:0] lru);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_target = utgt; update_taken = utk;
    lru_line = lru;
    model_step(lv, lpc, uv, upc, utgt, utk, lru);
    @(posedge clk); #1;
    check("pred_valid",   32'(pred_valid),   32'(e_pv));
    check("pred_hit",     32'(pred_hit),     32'(e_ph));
    check("pred_target",  pred_target,       e_pt);
    check("lru_en",       32'(lru_en),       32'(e_en));
    check("lru_hit",      32'(lru_hit),      32'(e_hit));
    check("lru_hit_line", 32'(lru_hit_line), 32'(e_line));
  endtask

  task automatic lookup(input logic [31:0] pc);
    drive(1, pc, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                        input logic [2:0] lru);
    drive(0, 0, 1, pc, tgt, tk, lru);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    lookup_valid = 0; lookup_pc = 0; update_valid = 0; update_pc = 0;
    update_target = 0; update_taken = 0; lru_line = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    lookup_valid = 0; lookup_pc = 0; update_valid = 0; update_pc = 0;
    update_target = 0; update_taken = 0; lru_line = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_valid", 32'(pred_valid), 32'h0);
    check("rst_pred_hit",   32'(pred_hit),   32'h0);
    check("rst_pred_tgt",   pred_target,     32'h0);
    check("rst_lru_en",     32'(lru_en),     32'h0);
    check("rst_lru_hit",    32'(lru_hit),    32'h0);
    check("rst_lru_line",   32'(lru_hit_line), 32'h0);
    rst = 1'b1;

    // Empty table lookup, then first allocation lands in line 0.
    lookup(32'h1000);
    check("empty_hit", 32'(pred_hit), 32'h0);
    update(32'h1000, 32'h2000, 1, 3'd5);
    check("alloc0_line", 32'(lru_hit_line), 32'h0);
    check("alloc0_en",   32'(lru_en),       32'h1);
    lookup(32'h1000);
    check("alloc0_tgt",  pred_target,       32'h2000);

    // Full table: ninth allocation evicts lru_line.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      update(32'h100 * i, 32'hA000 + i, 1, 3'd0);
      check("fill_line", 32'(lru_hit_line), 32'(i - 1));
    end
    update(32'h900, 32'hB900, 1, 3'd3);
    check("evict_en",  32'(lru_en),  32'h1);
    check("evict_hit", 32'(lru_hit), 32'h0);
    lookup(32'h400);
    check("evicted_miss", 32'(pred_hit), 32'h0);
    lookup(32'h900);
    check("victim_hit", pred_target, 32'hB900);

    // Not-taken update invalidates; the hole is reused first.
    do_reset();
    update(32'h1000, 32'h2000, 1, 3'd0);
    for (int i = 2; i <= 8; i++) update(32'h100 * i, 32'hC000 + i, 1, 3'd0);
    update(32'h1000, 32'h0, 0, 3'd4);
    check("inval_no_touch", 32'(lru_en), 32'h0);
    lookup(32'h1000);
    check("inval_miss", 32'(pred_hit), 32'h0);
    update(32'hA00, 32'hDA00, 1, 3'd6);
    check("reuse_line", 32'(lru_hit_line), 32'h0);
    check("reuse_hit",  32'(lru_hit),      32'h1);

    // Simultaneous lookup hit and allocating update: update touch wins.
    do_reset();
    update(32'h1000, 32'h2000, 1, 3'd0);
    drive(1, 32'h1000, 1, 32'h3000, 32'h3300, 1, 3'd7);
    check("both_line", 32'(lru_hit_line), 32'h1);
    check("both_pred", 32'(pred_hit),     32'h1);
    drive(1, 32'h1000, 1, 32'h1000, 32'h5000, 1, 3'd0);
`ifdef BTB_BYPASS_EN
    check("same_pc_tgt", pred_target, 32'h5000);
`else
    check("same_pc_tgt", pred_target, 32'h2000);
`endif
    lookup(32'h1000);
    check("retarget", pred_target, 32'h5000);

    // Reset asserted mid-lookup clears outputs without waiting for a clock.
    lookup_valid = 1; lookup_pc = 32'h1000; update_valid = 0;
    @(posedge clk); #2;
    check("pre_rst_valid", 32'(pred_valid), 32'h1);
    rst = 1'b0;
    #1;
    check("async_pred_valid", 32'(pred_valid), 32'h0);
    check("async_lru_en",     32'(lru_en),     32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    lookup(32'h1000);
    check("post_rst_miss", 32'(pred_hit), 32'h0);
    lookup(32'h3000);

    // Random traffic over a small PC pool so hits, evictions and collisions all occur.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        lv, uv, tk;
      logic [31:0] lpc, upc, tgt;
      logic [2:0]  lru;
      lv  = ($urandom_range(0, 9) < 7);
      uv  = ($urandom_range(0, 9) < 6);
      tk  = ($urandom_range(0, 9) < 7);
      lpc = 32'h100 * $urandom_range(1, 12);
      upc = ($urandom_range(0, 3) == 0) ? lpc : 32'h100 * $urandom_range(1, 12);
      tgt = $urandom;
      lru = 3'($urandom_range(0, 7));
      drive(lv, lpc, uv, upc, tgt, tk, lru);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
